// File: rtl/universal_shift_register_pkg.sv
`default_nettype none
// ============================================================================
// Package     : usr_pkg
// Description : Shared mode encoding for the universal shift register.
// Revision    : 1.0 - initial release
// ============================================================================
package usr_pkg;

  typedef logic [1:0] usr_mode_t;

  localparam usr_mode_t MODE_HOLD = 2'b00;
  localparam usr_mode_t MODE_SHL  = 2'b01;
  localparam usr_mode_t MODE_SHR  = 2'b10;
  localparam usr_mode_t MODE_LOAD = 2'b11;

endpackage
`default_nettype wire

// File: rtl/universal_shift_register_frame_counter.sv
`default_nettype none
// ============================================================================
// Module      : usr_frame_counter
// Description : Modulo-WIDTH shift counter with a registered frame_done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module usr_frame_counter #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift_evt,
  input  logic             restart,
  output logic [CNT_W-1:0] count,
  output logic             frame_done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] count_q, count_d;
  logic             frame_q, frame_d;

  // restart (clear or load) outranks a shift event in the same cycle
  always_comb begin
    count_d = count_q;
    frame_d = 1'b0;
    if (restart) begin
      count_d = '0;
    end else if (shift_evt) begin
      if (count_q == LAST) begin
        count_d = '0;
        frame_d = 1'b1;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      frame_q <= 1'b0;
    end else begin
      count_q <= count_d;
      frame_q <= frame_d;
    end
  end

  assign count      = count_q;
  assign frame_done = frame_q;

endmodule
`default_nettype wire

// File: rtl/universal_shift_register.sv
`default_nettype none
// ============================================================================
// Module      : universal_shift_register
// Description : Left/right shift, parallel load, clear, enable, frame counter.
//               Define ROTATE_EN to add the rot port (rotate instead of shift).
// Revision    : 1.0 - initial release
// ============================================================================
module universal_shift_register
  import usr_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  usr_mode_t        mode,
`ifdef ROTATE_EN
  input  logic             rot,
`endif
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic [WIDTH-1:0] pdata,
  output logic [WIDTH-1:0] data_out,
  output logic             sout_msb,
  output logic             sout_lsb,
  output logic [CNT_W-1:0] shift_count,
  output logic             frame_done
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             fill_l, fill_r;
  logic             shift_evt, restart;

`ifdef ROTATE_EN
  assign fill_l = rot ? data_q[WIDTH-1] : sin_l;
  assign fill_r = rot ? data_q[0]       : sin_r;
`else
  assign fill_l = sin_l;
  assign fill_r = sin_r;
`endif

  always_comb begin
    data_d = data_q;
    if (clr) begin
      data_d = '0;
    end else if (en) begin
      case (mode)
        MODE_SHL:  data_d = {data_q[WIDTH-2:0], fill_l};
        MODE_SHR:  data_d = {fill_r, data_q[WIDTH-1:1]};
        MODE_LOAD: data_d = pdata;
        default:   data_d = data_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) data_q <= '0;
    else       data_q <= data_d;
  end

  assign shift_evt = !clr && en && ((mode == MODE_SHL) || (mode == MODE_SHR));
  assign restart   = clr || (en && (mode == MODE_LOAD));

  usr_frame_counter #(.WIDTH(WIDTH)) u_frame_counter (
    .clk        (clk),
    .reset      (reset),
    .shift_evt  (shift_evt),
    .restart    (restart),
    .count      (shift_count),
    .frame_done (frame_done)
  );

  assign data_out = data_q;
  assign sout_msb = data_q[WIDTH-1];
  assign sout_lsb = data_q[0];

endmodule
`default_nettype wire

// File: tb/tb_universal_shift_register.sv
`default_nettype none
// ============================================================================
// Module      : tb_universal_shift_register
// Description : Self-checking bench for universal_shift_register (WIDTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_universal_shift_register;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset, en, clr, rot, sin_l, sin_r;
  logic [1:0]   mode;
  logic [W-1:0] pdata;
  logic [W-1:0] data_out;
  logic         sout_msb, sout_lsb, frame_done;
  logic [2:0]   shift_count;

  int errors = 0;
  int checks = 0;

  // reference state: register value as an integer 0..255, shifts mod 8
  int   m_val = 0;
  int   m_cnt = 0;
  logic m_fd  = 1'b0;

  universal_shift_register #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .clr         (clr),
    .mode        (mode),
`ifdef ROTATE_EN
    .rot         (rot),
`endif
    .sin_l       (sin_l),
    .sin_r       (sin_r),
    .pdata       (pdata),
    .data_out    (data_out),
    .sout_msb    (sout_msb),
    .sout_lsb    (sout_lsb),
    .shift_count (shift_count),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  task automatic model_edge();
    bit r;
`ifdef ROTATE_EN
    r = rot;
`else
    r = 1'b0;
`endif
    if (clr) begin
      m_val = 0; m_cnt = 0; m_fd = 1'b0;
    end else if (!en || mode == 2'b00) begin
      m_fd = 1'b0;
    end else if (mode == 2'b11) begin
      m_val = int'(pdata); m_cnt = 0; m_fd = 1'b0;
    end else begin
      if (mode == 2'b01)
        m_val = (m_val * 2) % 256 + (r ? m_val / 128 : int'(sin_l));
      else
        m_val = m_val / 2 + 128 * (r ? m_val % 2 : int'(sin_r));
      m_cnt = (m_cnt + 1) % W;
      m_fd  = (m_cnt == 0);
    end
  endtask

  task automatic check(input string tag);
    logic [7:0] exp_d;
    exp_d = 8'(m_val);
    checks++;
    assert (data_out === exp_d) else begin
      errors++; $error("FAIL %s data_out=%h expected=%h", tag, data_out, exp_d);
    end
    checks++;
    assert (shift_count === 3'(m_cnt)) else begin
      errors++; $error("FAIL %s shift_count=%0d expected=%0d", tag, shift_count, m_cnt);
    end
    checks++;
    assert (frame_done === m_fd) else begin
      errors++; $error("FAIL %s frame_done=%b expected=%b", tag, frame_done, m_fd);
    end
    checks++;
    assert ({sout_msb, sout_lsb} === {exp_d[7], exp_d[0]}) else begin
      errors++; $error("FAIL %s taps=%b%b expected=%b%b", tag, sout_msb, sout_lsb, exp_d[7], exp_d[0]);
    end
  endtask

  task automatic cyc(input string tag, input logic e, input logic c, input logic [1:0] md,
                     input logic sl, input logic sr, input logic r, input logic [7:0] pd);
    en = e; clr = c; mode = md; sin_l = sl; sin_r = sr; rot = r; pdata = pd;
    @(posedge clk);
    model_edge();
    #1;
    check(tag);
  endtask

  task automatic expect_val(input string tag, input logic [7:0] v);
    checks++;
    assert (data_out === v) else begin
      errors++; $error("FAIL %s data_out=%h expected=%h", tag, data_out, v);
    end
  endtask

  initial begin
    logic [7:0] pat;
    int         pulses;
    logic [7:0] held;

    reset = 1'b1; en = 1'b0; clr = 1'b0; mode = 2'b00;
    sin_l = 1'b0; sin_r = 1'b0; rot = 1'b0; pdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state");
    reset = 1'b0;

    // stream some data, then reset between edges
    cyc("pre_load", 1, 0, 2'b11, 0, 0, 0, 8'h5A);
    cyc("pre_shl", 1, 0, 2'b01, 1, 0, 0, 8'h00);
    #2 reset = 1'b1;
    #1;
    m_val = 0; m_cnt = 0; m_fd = 1'b0;
    check("async_reset");
    @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 8; i++) cyc("fill_ones", 1, 0, 2'b01, 1, 0, 0, 8'h00);
    expect_val("fill_ones_ff", 8'hFF);
    checks++;
    assert (frame_done === 1'b1) else begin
      errors++; $error("FAIL fill_ones_fd frame_done=%b expected=1", frame_done);
    end

    cyc("clr0", 1, 1, 2'b00, 0, 0, 0, 8'h00);
    pat = 8'b1011_0010;
    for (int i = 7; i >= 0; i--) cyc("sil_pattern", 1, 0, 2'b01, pat[i], 0, 0, 8'h00);
    expect_val("sil_b2", 8'hB2);

    cyc("load_81", 1, 0, 2'b11, 0, 0, 0, 8'h81);
    expect_val("load_81_val", 8'h81);
    for (int i = 0; i < 3; i++) cyc("shr3", 1, 0, 2'b10, 0, 0, 0, 8'h00);
    expect_val("shr3_10", 8'h10);

    cyc("clr_over_load", 0, 1, 2'b11, 0, 0, 0, 8'hFF);
    expect_val("clr_over_load_0", 8'h00);

    cyc("setup_hold", 1, 0, 2'b11, 0, 0, 0, 8'h3C);
    cyc("setup_hold_sh", 1, 0, 2'b01, 1, 0, 0, 8'h00);
    held = data_out;
    for (int i = 0; i < 5; i++) cyc("en_low_hold", 0, 0, 2'b01, 1, 1, 0, 8'hAA);
    expect_val("en_low_held", held);

    cyc("clr_frame", 1, 1, 2'b00, 0, 0, 0, 8'h00);
    pulses = 0;
    for (int i = 1; i <= 24; i++) begin
      cyc("frame_cont", 1, 0, (i % 3 == 0) ? 2'b10 : 2'b01, 1'(i), 1'(i >> 1), 0, 8'h00);
      if (frame_done) pulses++;
      checks++;
      assert (frame_done === (i % 8 == 0)) else begin
        errors++; $error("FAIL frame_edge edge=%0d frame_done=%b expected=%b", i, frame_done, (i % 8 == 0));
      end
    end
    checks++;
    assert (pulses == 3) else begin
      errors++; $error("FAIL frame_pulses count=%0d expected=3", pulses);
    end

`ifdef ROTATE_EN
    cyc("rot_load", 1, 0, 2'b11, 0, 0, 0, 8'h81);
    cyc("rot_left", 1, 0, 2'b01, 0, 0, 1, 8'h00);
    expect_val("rot_left_03", 8'h03);
    cyc("rot_right1", 1, 0, 2'b10, 1, 0, 1, 8'h00);
    cyc("rot_right2", 1, 0, 2'b10, 0, 1, 1, 8'h00);
    expect_val("rot_right_c0", 8'hC0);
`endif

    for (int i = 0; i < 300; i++) begin
      cyc("random", ($urandom_range(0, 7) != 0), ($urandom_range(0, 31) == 0),
          2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
